// File: rtl/hamming_seq_if.sv
// Operand/result handshake bundle for hamming_seq. The DUT side uses the
// slave modport; whoever feeds operands and drains results uses master.
interface hamming_seq_if #(
    parameter int N  = 16,
    parameter int DW = $clog2(N + 1)
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in1;
    logic [N-1:0]  in2;
    logic [DW-1:0] thresh;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] hamming;
    logic          match;
    logic          busy;
    logic [1:0]    state_dbg;

    modport slave (
        input  in_valid, in1, in2, thresh, out_ready,
        output in_ready, out_valid, hamming, match, busy, state_dbg
    );

    modport master (
        output in_valid, in1, in2, thresh, out_ready,
        input  in_ready, out_valid, hamming, match, busy, state_dbg
    );
endinterface

// File: rtl/hamming_seq.sv
// Sequential Hamming distance: popcounts P bits of in1^in2 per cycle over
// N/P cycles, then holds the distance and threshold match until consumed.
module hamming_seq #(
    parameter int N = 16,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    hamming_seq_if.slave bus
);
    localparam int DW    = $clog2(N + 1);
    localparam int STEPS = N / P;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (N < 2 || P < 1 || P > N || (N % P) != 0) begin : g_bad_params
        $error("hamming_seq: N must be >= 2 and a multiple of P, 1 <= P <= N");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // A producer holds its payload stable while valid is high and not yet
    // taken; ready may depend combinationally on the consumer's ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  shift_q;
    logic [DW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] thr_q;
    logic [DW-1:0] pc;
    logic          accept;
    logic          last_step;

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign last_step     = (cnt_q == CW'(STEPS - 1));

    assign bus.busy      = (state == COUNT);
    assign bus.out_valid = (state == DONE);
    assign bus.hamming   = (state == DONE) ? acc_q : '0;
    assign bus.match     = (state == DONE) && (acc_q <= thr_q);
    assign bus.state_dbg = state;

    always_comb begin
        pc = '0;
        for (int i = 0; i < P; i++) begin
            pc = pc + DW'(shift_q[i]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = COUNT;
            COUNT:   if (last_step) state_nxt = DONE;
            DONE: begin
                if (bus.out_ready) state_nxt = accept ? COUNT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands are captured only on accept, so input changes mid-count are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
        end else if (accept) begin
            shift_q <= bus.in1 ^ bus.in2;
            acc_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= bus.thresh;
        end else if (state == COUNT) begin
            shift_q <= shift_q >> P;
            acc_q   <= acc_q + pc;
            cnt_q   <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hamming_seq.sv
// Directed bench for hamming_seq (N=16, P=4): latency, backpressure,
// back-to-back accepts, input isolation and mid-count reset.
module tb_hamming_seq;
    localparam int N     = 16;
    localparam int P     = 4;
    localparam int DW    = 5;
    localparam int STEPS = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hamming_seq_if #(.N(N), .DW(DW)) bus ();

    hamming_seq #(.N(N), .P(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic [DW-1:0] th,
                         input logic [DW-1:0] eh, input logic em);
        bus.in1      = a;
        bus.in2      = b;
        bus.thresh   = th;
        bus.in_valid = 1'b1;
        exp_q.push_back({em, eh});
    endtask

    // Steps negedge by negedge until out_valid, bounded; lat counts negedges.
    task automatic wait_out(input bit keep, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (!keep) bus.in_valid = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic collect(input string tag);
        logic [DW:0] e;
        e = '0;
        check({tag, " out_valid"}, bus.out_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, " exp_q empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " hamming"}, bus.hamming, e[DW-1:0]);
            check({tag, " match"}, bus.match, e[DW]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, cnt;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.thresh    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", bus.in_ready, 1);
        check("rst out_valid", bus.out_valid, 0);
        check("rst busy", bus.busy, 0);
        check("rst hamming", bus.hamming, 0);
        check("rst match", bus.match, 0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Basic op: fixed latency and busy duration
        drive(16'hAAAA, 16'hCCCC, 5'd8, 5'd8, 1'b1);
        wait_out(1'b0, lat, bcnt);
        check("t1 latency", lat - 1, STEPS);
        check("t1 busy cycles", bcnt, STEPS);
        collect("t1");
        @(negedge clk);
        check("t1 idle out_valid", bus.out_valid, 0);
        check("t1 idle in_ready", bus.in_ready, 1);
        check("t1 idle hamming", bus.hamming, 0);

        // Identical operands with thresh 0, then all-ones distance
        drive(16'h1234, 16'h1234, 5'd0, 5'd0, 1'b1);
        wait_out(1'b0, lat, bcnt);
        collect("t2 equal");
        @(negedge clk);
        drive(16'hFFFF, 16'h0000, 5'd15, 5'd16, 1'b0);
        wait_out(1'b0, lat, bcnt);
        collect("t2 full");
        @(negedge clk);
        drive(16'hFFFF, 16'h0000, 5'd16, 5'd16, 1'b1);
        wait_out(1'b0, lat, bcnt);
        collect("t2 thresh N");
        @(negedge clk);
        drive(16'h0F0F, 16'h0000, 5'd31, 5'd8, 1'b1);
        wait_out(1'b0, lat, bcnt);
        collect("t2 thresh max");
        @(negedge clk);

        // Backpressure: result held while out_ready is low
        bus.out_ready = 1'b0;
        drive(16'hAAAA, 16'h0000, 5'd3, 5'd8, 1'b0);
        wait_out(1'b0, lat, bcnt);
        collect("t3");
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.hamming == 5'd8 && !bus.match && !bus.in_ready) cnt++;
        end
        check("t3 held cycles", cnt, 5);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3 release out_valid", bus.out_valid, 0);
        check("t3 release in_ready", bus.in_ready, 1);
        check("t3 release state", bus.state_dbg, 0);

        // Back-to-back accepts with in_valid held
        drive(16'hAAAA, 16'hCCCC, 5'd8, 5'd8, 1'b1);
        wait_out(1'b1, lat, bcnt);
        collect("t4 first");
        drive(16'h000F, 16'h0000, 5'd4, 5'd4, 1'b1);
        wait_out(1'b0, lat, bcnt);
        check("t4 gap", lat, STEPS + 1);
        collect("t4 second");
        @(negedge clk);

        // Inputs changed during COUNT must not leak into the result
        drive(16'h0003, 16'h0000, 5'd1, 5'd2, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in1      = 16'hFFFF;
        bus.in2      = 16'h0000;
        bus.thresh   = 5'd31;
        wait_out(1'b0, lat, bcnt);
        check("t5 latency", lat, STEPS);
        collect("t5");
        @(negedge clk);

        // Reset on the second COUNT cycle discards the operation
        bus.in1      = 16'h00FF;
        bus.in2      = 16'h0000;
        bus.thresh   = 5'd8;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t6 busy before rst", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6 rst busy", bus.busy, 0);
        check("t6 rst in_ready", bus.in_ready, 1);
        check("t6 rst out_valid", bus.out_valid, 0);
        check("t6 rst hamming", bus.hamming, 0);
        check("t6 rst match", bus.match, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("t6 no stale result", cnt, 0);

        // Accept on the first edge after reset release
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0001, 16'h0000, 5'd0, 5'd1, 1'b0);
        wait_out(1'b0, lat, bcnt);
        check("t7 latency", lat - 1, STEPS);
        collect("t7");
        @(negedge clk);
        check("t7 exp_q drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hamming_seq.md
HAMMING_SEQ -- requirements
Module: hamming_seq

Interface
REQ-001 SHALL have parameter N, default 16: operand width in bits, N >= 2.
REQ-002 SHALL have parameter P, default 4: bits examined per cycle; 1 <= P <= N, N mod P == 0; elaboration SHALL fail otherwise.
REQ-003 SHALL have derived localparams DW = clog2(N+1) (result width) and STEPS = N/P.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand pair on in1/in2/thresh is valid.
REQ-007 in_ready  output  1  block can accept an operand pair this cycle.
REQ-008 in1  input  N  first operand.
REQ-009 in2  input  N  second operand.
REQ-010 thresh  input  DW  match threshold, sampled with the operands.
REQ-011 out_valid  output  1  result on hamming/match is valid.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 hamming  output  DW  Hamming distance (popcount of in1 XOR in2).
REQ-014 match  output  1  1 when hamming <= sampled thresh.
REQ-015 busy  output  1  1 while a computation is in progress (state COUNT).

Function
REQ-016 SHALL implement FSM states IDLE, COUNT, DONE; IDLE after reset.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready is 1, 0 in COUNT.
REQ-018 Accept = in_valid && in_ready; on accept: shift register <= in1 ^ in2, accumulator <= 0, step counter <= 0, thresh register <= thresh, state -> COUNT.
REQ-019 Each COUNT cycle: accumulator += popcount(shift[P-1:0]); shift >>= P; counter += 1.
REQ-020 When the counter reaches STEPS-1 in COUNT, the final addition SHALL occur and state -> DONE on that edge.
REQ-021 Latency SHALL be fixed: out_valid rises exactly STEPS cycles after the accepting edge, independent of data.
REQ-022 In DONE: out_valid = 1, hamming = accumulator, match = (accumulator <= thresh register); all SHALL be held stable until out_ready = 1.
REQ-023 DONE with out_ready = 1 and in_valid = 0 -> IDLE; out_ready = 1 and in_valid = 1 -> new accept and state -> COUNT (back-to-back, no bubble cycle).
REQ-024 in_valid in COUNT SHALL be ignored; in1/in2/thresh changes after accept SHALL NOT affect the result.
REQ-025 Accumulator SHALL be DW bits wide; the maximum value N SHALL be representable without overflow.
REQ-026 thresh >= N SHALL always give match = 1; thresh = 0 SHALL give match = 1 only for identical operands.
REQ-027 out_valid, hamming, and match SHALL be 0 outside DONE.
REQ-028 busy SHALL equal (state == COUNT).

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force state IDLE, in_ready 1, out_valid 0, busy 0, hamming 0, match 0, and clear shift, accumulator, counter, and thresh registers.
REQ-030 Reset asserted mid-COUNT or in DONE SHALL discard the operation; no result SHALL be emitted after release.
REQ-031 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (N=16, P=4, STEPS=4, DW=5)
REQ-032 in1=0xAAAA, in2=0xCCCC, thresh=8, out_ready=1 -> out_valid high 4 cycles after accept, hamming=8, match=1; busy high for exactly 4 cycles.
REQ-033 in1=in2=0x1234, thresh=0 -> hamming=0, match=1; in1=0xFFFF, in2=0x0000, thresh=15 -> hamming=16, match=0 (no overflow).
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, hamming, and match held constant, in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-035 Back-to-back: in_valid held with two pairs (0xAAAA/0xCCCC, then 0x000F/0x0000), out_ready=1 -> results 8 then 4, second out_valid exactly 5 cycles after the first.
REQ-036 Inputs changed to 0xFFFF/0x0000 during COUNT -> result still reflects the sampled pair.
REQ-037 rst_n pulsed low on the 2nd COUNT cycle -> all outputs reset immediately; no out_valid afterwards; a fresh accept 0x0001/0x0000 -> hamming=1.
